// File: rtl/bounce_box_src.sv
// Test-pattern source: a coloured square bounces inside a one-pixel border.
// Pixels are produced on request with one cycle of latency.
module bounce_box_src #(
  parameter int BITS_PER_COLOR = 8,
  parameter int BOX_SIZE       = 32,
  parameter int STEP           = 2
) (
  input  logic                          i_pixclk,
  input  logic                          i_reset_n,
  input  logic [10:0]                   i_width,
  input  logic [10:0]                   i_height,
  input  logic                          i_rd,
  input  logic                          i_newline,
  input  logic                          i_newframe,
  output logic [3*BITS_PER_COLOR-1:0]   o_pixel
);

  localparam int PW = 12;
  localparam logic [PW-1:0] BOX_W  = PW'(BOX_SIZE);
  localparam logic [PW-1:0] STEP_W = PW'(STEP);
  // 0x40 per channel, kept MSB-aligned for any channel width.
  localparam logic [BITS_PER_COLOR-1:0] BORDER_CH =
    (BITS_PER_COLOR >= 2) ? (BITS_PER_COLOR'(1) << (BITS_PER_COLOR - 2)) : '0;

  typedef struct packed {
    logic [10:0] pos;
    logic        neg;
    logic        bounce;
  } axis_t;

  function automatic axis_t move_axis(input logic [10:0] pos,
                                      input logic        neg,
                                      input logic [10:0] lim);
    axis_t       r;
    logic [PW-1:0] nx;
    logic [PW-1:0] lim_w;
    r.pos    = pos;
    r.neg    = neg;
    r.bounce = 1'b0;
    lim_w    = {1'b0, lim};
    nx       = {1'b0, pos} + STEP_W;
    if (lim_w <= BOX_W) begin
      r.pos = '0;
    end else if (!neg) begin
      if (nx + BOX_W > lim_w) begin
        r.pos    = 11'(lim_w - BOX_W);
        r.neg    = 1'b1;
        r.bounce = 1'b1;
      end else begin
        r.pos = 11'(nx);
      end
    end else begin
      if ({1'b0, pos} < STEP_W) begin
        r.pos    = '0;
        r.neg    = 1'b0;
        r.bounce = 1'b1;
      end else begin
        r.pos = 11'({1'b0, pos} - STEP_W);
      end
    end
    return r;
  endfunction

  logic [10:0]                 r_col, r_row;
  logic [10:0]                 r_bx, r_by;
  logic                        r_dx_neg, r_dy_neg;
  logic [2:0]                  r_cidx;
  logic [3*BITS_PER_COLOR-1:0] r_pixel;

  axis_t                       w_mx, w_my;
  logic                        w_bounce;
  logic                        w_in_box, w_border;
  logic [3*BITS_PER_COLOR-1:0] w_colour;

  // NOTE: every signal driven here gets a default first so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    w_mx     = move_axis(r_bx, r_dx_neg, i_width);
    w_my     = move_axis(r_by, r_dy_neg, i_height);
    w_bounce = w_mx.bounce | w_my.bounce;

    w_in_box = ({1'b0, r_col} >= {1'b0, r_bx}) && ({1'b0, r_col} < {1'b0, r_bx} + BOX_W) &&
               ({1'b0, r_row} >= {1'b0, r_by}) && ({1'b0, r_row} < {1'b0, r_by} + BOX_W);
    w_border = (r_col == 11'd0) || (r_row == 11'd0) ||
               (r_col == i_width - 11'd1) || (r_row == i_height - 11'd1);

    w_colour = '0;
    if (w_in_box) begin
      w_colour = {{BITS_PER_COLOR{r_cidx[2]}},
                  {BITS_PER_COLOR{r_cidx[1]}},
                  {BITS_PER_COLOR{r_cidx[0]}}};
    end else if (w_border) begin
      w_colour = {BORDER_CH, BORDER_CH, BORDER_CH};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_pixclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_col    <= '0;
      r_row    <= '0;
      r_bx     <= '0;
      r_by     <= '0;
      r_dx_neg <= 1'b0;
      r_dy_neg <= 1'b0;
      r_cidx   <= 3'd7;
      r_pixel  <= '0;
    end else if (i_newframe) begin
      r_col    <= '0;
      r_row    <= '0;
      r_bx     <= w_mx.pos;
      r_dx_neg <= w_mx.neg;
      r_by     <= w_my.pos;
      r_dy_neg <= w_my.neg;
      // A frame bouncing on both axes still advances the colour only once.
      if (w_bounce) r_cidx <= (r_cidx == 3'd7) ? 3'd1 : r_cidx + 3'd1;
    end else if (i_newline) begin
      r_col <= '0;
      if (r_row != 11'h7FF) r_row <= r_row + 11'd1;
    end else if (i_rd) begin
      r_pixel <= w_colour;
      if (r_col != 11'h7FF) r_col <= r_col + 11'd1;
    end
  end

  assign o_pixel = r_pixel;

endmodule

// File: tb/tb_bounce_box_src.sv
// Directed bench for bounce_box_src: scan output, motion/bounce, event
// priority and asynchronous reset, with hand-computed expected pixels.
module tb_bounce_box_src;

  localparam logic [23:0] WHITE  = 24'hFFFFFF;
  localparam logic [23:0] BLUE   = 24'h0000FF;
  localparam logic [23:0] GREEN  = 24'h00FF00;
  localparam logic [23:0] BORDER = 24'h404040;
  localparam logic [23:0] BLACK  = 24'h000000;

  logic        pixclk = 1'b0;
  logic        reset_n = 1'b1;
  logic [10:0] width = 11'd640;
  logic [10:0] height = 11'd480;
  logic        rd = 1'b0, newline = 1'b0, newframe = 1'b0;
  logic [23:0] pixel;

  int n_vec = 0;
  int n_err = 0;
  int tb_col = 0;
  int tb_row = 0;

  bounce_box_src dut (
    .i_pixclk  (pixclk),
    .i_reset_n (reset_n),
    .i_width   (width),
    .i_height  (height),
    .i_rd      (rd),
    .i_newline (newline),
    .i_newframe(newframe),
    .o_pixel   (pixel)
  );

  always #5 pixclk = ~pixclk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input logic nf, input logic nl, input logic r);
    @(negedge pixclk);
    newframe = nf;
    newline  = nl;
    rd       = r;
    @(posedge pixclk);
    #1;
    newframe = 1'b0;
    newline  = 1'b0;
    rd       = 1'b0;
  endtask

  task automatic expect_pix(input logic [23:0] exp, input string name);
    n_vec++;
    if (pixel !== exp) begin
      n_err++;
      $display("FAIL %s: got %06h expected %06h", name, pixel, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge pixclk);
    reset_n = 1'b0;
    repeat (2) @(negedge pixclk);
    reset_n = 1'b1;
    tb_col = 0;
    tb_row = 0;
  endtask

  task automatic do_newframe();
    cyc(1'b1, 1'b0, 1'b0);
    tb_col = 0;
    tb_row = 0;
  endtask

  task automatic do_newline();
    cyc(1'b0, 1'b1, 1'b0);
    tb_col = 0;
    tb_row++;
  endtask

  task automatic do_rd();
    cyc(1'b0, 1'b0, 1'b1);
    tb_col++;
  endtask

  // Advance the scan to (c, r) and compare the pixel produced for it.
  task automatic probe(input int c, input int r, input logic [23:0] exp, input string name);
    if (r < tb_row || (r == tb_row && c < tb_col)) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: probe (%0d,%0d) behind scan (%0d,%0d)", name, c, r, tb_col, tb_row);
    end else begin
      while (tb_row < r) do_newline();
      while (tb_col <= c) do_rd();
      n_vec++;
      if (pixel !== exp) begin
        n_err++;
        $display("FAIL %s (col %0d row %0d): got %06h expected %06h", name, c, r, pixel, exp);
      end
    end
  endtask

  task automatic test_reset();
    width = 11'd640; height = 11'd480;
    @(negedge pixclk);
    reset_n = 1'b0;
    #1;
    expect_pix(BLACK, "reset_asserted");
    repeat (2) @(negedge pixclk);
    reset_n = 1'b1;
    tb_col = 0; tb_row = 0;
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    expect_pix(BLACK, "idle_after_reset");
    do_newframe();
    expect_pix(BLACK, "newframe_holds_pixel");
  endtask

  task automatic test_scan();
    logic [23:0] exp;
    do_reset();
    width = 11'd640; height = 11'd480;
    do_newframe();
    repeat (3) do_newline();
    for (int c = 0; c < 40; c++) begin
      if (c == 0)                exp = BORDER;
      else if (c >= 2 && c < 34) exp = WHITE;
      else                       exp = BLACK;
      probe(c, 3, exp, "scan_row3");
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    width = 11'd640; height = 11'd480;
    do_newframe();
    probe(4, 3, WHITE, "pre_combo");
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    expect_pix(WHITE, "idle_hold");
    cyc(1'b0, 1'b1, 1'b1);
    tb_col = 0; tb_row = 4;
    expect_pix(WHITE, "newline_rd_holds");
    probe(0, 4, BORDER, "after_newline_col0");
    probe(1, 4, BLACK, "after_newline_col1");
    probe(2, 4, WHITE, "after_newline_col2");
    cyc(1'b1, 1'b1, 1'b1);
    tb_col = 0; tb_row = 0;
    expect_pix(WHITE, "frame_line_rd_holds");
    probe(4, 3, BLACK, "moved_once_above");
    probe(3, 4, BLACK, "moved_once_left");
    probe(4, 4, WHITE, "moved_once_corner");
  endtask

  task automatic test_sweep_640();
    do_reset();
    width = 11'd640; height = 11'd480;
    for (int f = 1; f <= 306; f++) begin
      do_newframe();
      case (f)
        224: begin
          probe(448, 447, BLACK, "f224_above");
          probe(447, 448, BLACK, "f224_left");
          probe(448, 448, WHITE, "f224_box");
        end
        225: begin
          probe(450, 447, BLACK, "f225_above");
          probe(450, 448, BLUE,  "f225_ybounce");
          probe(479, 479, BLUE,  "f225_box_over_border");
        end
        304: begin
          probe(608, 289, BLACK, "f304_above");
          probe(607, 290, BLACK, "f304_left");
          probe(608, 290, BLUE,  "f304_box");
          probe(639, 290, BLUE,  "f304_right_edge");
        end
        305: begin
          probe(607, 288, BLACK, "f305_left");
          probe(608, 288, GREEN, "f305_xbounce");
        end
        306: begin
          probe(605, 286, BLACK, "f306_left");
          probe(606, 286, GREEN, "f306_moving_left");
          probe(639, 286, BORDER, "f306_border");
          probe(640, 286, BLACK, "f306_outside");
        end
        default: ;
      endcase
    end
  endtask

  task automatic test_simul_bounce();
    do_reset();
    width = 11'd96; height = 11'd96;
    for (int f = 1; f <= 34; f++) begin
      do_newframe();
      case (f)
        32: begin
          probe(63, 64, BLACK, "f32_left");
          probe(64, 64, WHITE, "f32_box");
        end
        33: begin
          probe(64, 64, BLUE, "f33_both_bounce");
          probe(95, 95, BLUE, "f33_corner");
        end
        34: begin
          probe(61, 62, BLACK, "f34_left");
          probe(62, 62, BLUE,  "f34_single_advance");
        end
        default: ;
      endcase
    end
  endtask

  // Continues from the 96x96 state (box at 62,62 moving up-left, blue).
  task automatic test_narrow();
    width = 11'd20;
    do_newframe();
    probe(0, 60, BLUE,  "narrow_box_col0");
    probe(31, 60, BLUE, "narrow_box_col31");
    probe(32, 60, BLACK, "narrow_outside");
    do_newframe();
    probe(0, 58, BLUE, "narrow_no_bounce");
  endtask

  task automatic test_reset_midline();
    do_reset();
    width = 11'd640; height = 11'd480;
    do_newframe();
    probe(2, 2, WHITE, "pre_reset");
    @(posedge pixclk);
    #2;
    reset_n = 1'b0;
    #1;
    expect_pix(BLACK, "async_reset_clears");
    @(negedge pixclk);
    @(negedge pixclk);
    reset_n = 1'b1;
    tb_col = 0; tb_row = 0;
    cyc(1'b0, 1'b0, 1'b0);
    expect_pix(BLACK, "no_pixel_after_release");
    do_newframe();
    expect_pix(BLACK, "release_frame_holds");
    probe(1, 2, BLACK, "restart_left");
    probe(2, 2, WHITE, "restart_box");
    probe(33, 2, WHITE, "restart_box_right");
    probe(34, 2, BLACK, "restart_past_box");
  endtask

  initial begin
    test_reset();
    test_scan();
    test_same_cycle();
    test_sweep_640();
    test_simul_bounce();
    test_narrow();
    test_reset_midline();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
